// File: rtl/next_pc_unit.sv
// next_pc_unit
//   Registered program-counter generator for the 5-stage MIPS core.
//   Owns the IF-stage PC, resolves beq/j/jal/jr from ID, exception entry and
//   eret. An optional return-address stack (RAS) predicts jr $31. When that
//   prediction is wrong, a one-cycle RECOVER state redirects to the real target.
// Ports
//   clk, rst       : clock and synchronous active-high reset
//   stall          : hold the PC
//   exc_req        : take exception (-> EXC_VECTOR)
//   eret_req, epc  : return from exception to epc
//   id_valid       : ID holds a valid instruction
//   pc4_id         : ID instruction address + 4
//   pc_src         : 0 seq, 1 beq, 2 j/jal, 3 jr
//   zero           : beq compare result
//   instr_id       : ID instruction word
//   is_link        : ID instruction is jal
//   jr_r31         : ID jr uses $31
//   rs_val         : architecturally correct jr target
//   pc, pc4        : current fetch PC and pc + 4
//   flush_if       : kill the instruction now in IF/ID
//   ras_mispredict : high in the RECOVER cycle
module next_pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0000_3000),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(32'h0000_4180),
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter int unsigned     USE_RAS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  input  logic            id_valid,
  input  logic [XLEN-1:0] pc4_id,
  input  logic [1:0]      pc_src,
  input  logic            zero,
  input  logic [31:0]     instr_id,
  input  logic            is_link,
  input  logic            jr_r31,
  input  logic [XLEN-1:0] rs_val,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            flush_if,
  output logic            ras_mispredict
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  typedef enum logic {NORMAL, RECOVER} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] rec_tgt, rec_tgt_next;
  logic            flush;

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW:0]     count;
  logic [XLEN-1:0] ras_top;
  logic            ras_hit, ras_en, push, pop;

  logic [XLEN-1:0] br_tgt, j_tgt;
  logic            unused_opcode;

  assign unused_opcode = ^instr_id[31:26];

  // ptr is the next free slot, so the top of stack sits one below it
  assign ras_top = ras[ptr - PW'(1)];
  assign ras_hit = (USE_RAS != 0) && jr_r31 && (count != '0);

  assign br_tgt = pc4_id + ({{(XLEN-16){instr_id[15]}}, instr_id[15:0]} << 2);
  assign j_tgt  = {pc4_id[XLEN-1:28], instr_id[25:0], 2'b00};

  always_comb begin
    pc_next      = pc_q + XLEN'(4);
    flush        = 1'b0;
    state_next   = NORMAL;
    rec_tgt_next = rec_tgt;
    if (exc_req) begin
      pc_next = EXC_VECTOR;
      flush   = 1'b1;
    end else if (eret_req) begin
      pc_next = epc;
      flush   = 1'b1;
    end else if (state == RECOVER) begin
      pc_next = rec_tgt;
      flush   = 1'b1;
    end else if (stall) begin
      pc_next = pc_q;
    end else if (id_valid && pc_src == 2'd1 && zero) begin
      pc_next = br_tgt;
      flush   = 1'b1;
    end else if (id_valid && pc_src == 2'd2) begin
      pc_next = j_tgt;
      flush   = 1'b1;
    end else if (id_valid && pc_src == 2'd3) begin
      flush = 1'b1;
      if (ras_hit) begin
        pc_next = ras_top;
        if (ras_top != rs_val) begin
          state_next   = RECOVER;
          rec_tgt_next = rs_val;
        end
      end else begin
        pc_next = rs_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state   <= NORMAL;
      rec_tgt <= '0;
    end else begin
      pc_q    <= pc_next;
      state   <= state_next;
      rec_tgt <= rec_tgt_next;
    end
  end

  // The stack is maintained even with USE_RAS=0 so the two builds track the
  // same call depth; a full push overwrites the oldest slot (the one at ptr).
  assign ras_en = !(stall || exc_req || eret_req);
  assign push   = ras_en && id_valid && pc_src == 2'd2 && is_link;
  assign pop    = ras_en && id_valid && pc_src == 2'd3 && jr_r31 && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != (PW+1)'(RAS_DEPTH)) count <= count + (PW+1)'(1);
    end else if (pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) ras[ptr] <= pc4_id;
  end

  assign pc             = pc_q;
  assign pc4            = pc_q + XLEN'(4);
  assign flush_if       = flush && !rst;
  assign ras_mispredict = (state == RECOVER) && !rst;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit
//   Directed bench for next_pc_unit. A negedge model (PC value, RAS as a
//   queue, recover flag) predicts pc/pc4/flush_if/ras_mispredict every cycle;
//   literal expectations in the stimulus pin the model itself.
module tb_next_pc_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req, eret_req, id_valid, zero, is_link, jr_r31;
  logic [31:0] epc, pc4_id, instr_id, rs_val;
  logic [1:0]  pc_src;
  logic [31:0] pc, pc4;
  logic        flush_if, ras_mispredict;

  int checks   = 0;
  int failures = 0;

  next_pc_unit #(
    .XLEN(XLEN), .RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC),
    .RAS_DEPTH(DEPTH), .USE_RAS(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .id_valid(id_valid), .pc4_id(pc4_id), .pc_src(pc_src),
    .zero(zero), .instr_id(instr_id), .is_link(is_link), .jr_r31(jr_r31),
    .rs_val(rs_val), .pc(pc), .pc4(pc4), .flush_if(flush_if),
    .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] m_pc, m_rec_tgt;
  bit          m_rec, m_valid = 0;
  logic [31:0] m_ras[$];

  always @(negedge clk) begin
    logic [31:0] nxt, top;
    bit          fl, go_rec;
    int          off;
    if (rst) begin
      chk("rst_flush", {31'b0, flush_if}, 32'd0);
      chk("rst_misp", {31'b0, ras_mispredict}, 32'd0);
      m_pc = RST_PC; m_rec = 0; m_ras.delete(); m_valid = 1;
    end else if (m_valid) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc4", pc4, m_pc + 32'd4);
      chk("m_misp", {31'b0, ras_mispredict}, {31'b0, m_rec});
      fl = 0; go_rec = 0; nxt = m_pc + 32'd4;
      top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0;
      if (exc_req) begin nxt = EXC_PC; fl = 1; end
      else if (eret_req) begin nxt = epc; fl = 1; end
      else if (m_rec) begin nxt = m_rec_tgt; fl = 1; end
      else if (stall) nxt = m_pc;
      else if (id_valid && pc_src == 2'd1 && zero) begin
        off = int'($signed(instr_id[15:0]));
        nxt = pc4_id + 32'(off * 4); fl = 1;
      end
      else if (id_valid && pc_src == 2'd2) begin
        nxt = (pc4_id & 32'hF000_0000) | ((instr_id & 32'h03FF_FFFF) * 4); fl = 1;
      end
      else if (id_valid && pc_src == 2'd3) begin
        fl = 1;
        if (jr_r31 && m_ras.size() > 0) begin
          nxt = top;
          if (top != rs_val) begin go_rec = 1; m_rec_tgt = rs_val; end
        end else nxt = rs_val;
      end
      chk("m_flush", {31'b0, flush_if}, {31'b0, fl});
      if (!(stall || exc_req || eret_req) && id_valid) begin
        if (pc_src == 2'd2 && is_link) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(pc4_id);
        end else if (pc_src == 2'd3 && jr_r31 && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
      m_pc = nxt; m_rec = go_rec;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; eret_req = 0; id_valid = 0; pc_src = 2'd0;
    zero = 0; is_link = 0; jr_r31 = 0; epc = '0; pc4_id = '0; instr_id = '0; rs_val = '0;
  endtask

  task automatic jal(input logic [31:0] link);
    idle(); id_valid = 1; pc_src = 2'd2; is_link = 1; pc4_id = link;
    instr_id = 32'h0C00_0C40;  // target 0x3100
  endtask

  task automatic jr31(input logic [31:0] rs);
    idle(); id_valid = 1; pc_src = 2'd3; jr_r31 = 1; rs_val = rs;
  endtask

  task automatic beq(input logic [31:0] p4, input logic [15:0] imm, input logic z);
    idle(); id_valid = 1; pc_src = 2'd1; pc4_id = p4; instr_id = {16'h1000, imm}; zero = z;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(); rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_flush", {31'b0, flush_if}, 32'd0);
    tick(); chk("free1", pc, 32'h3004);
    tick(); chk("free2", pc, 32'h3008);

    beq(32'h3008, 16'hFFFE, 1); #1 chk("beq_t_flush", {31'b0, flush_if}, 32'd1);
    tick(); chk("beq_t_pc", pc, 32'h3000);
    beq(32'h3008, 16'hFFFE, 0); #1 chk("beq_nt_flush", {31'b0, flush_if}, 32'd0);
    tick(); chk("beq_nt_pc", pc, 32'h3004);

    jal(32'h3010); tick(); chk("jal_pc", pc, 32'h3100);
    idle(); tick(); chk("seq_pc", pc, 32'h3104);
    jr31(32'h3010); tick(); chk("jr_ras_pc", pc, 32'h3010);
    chk("jr_ras_misp", {31'b0, ras_mispredict}, 32'd0);
    jr31(32'h3050); tick(); chk("jr_empty_pc", pc, 32'h3050);
    chk("jr_empty_misp", {31'b0, ras_mispredict}, 32'd0);
    idle(); tick();

    for (int i = 0; i < 5; i++) begin
      jal(32'h3104 + 32'(i) * 32'h100); tick();
    end
    for (int i = 0; i < 4; i++) begin
      jr31(32'h3504 - 32'(i) * 32'h100); tick();
      chk("nest_ret", pc, 32'h3504 - 32'(i) * 32'h100);
    end
    jr31(32'h3104); tick(); chk("nest_fifth", pc, 32'h3104);
    idle(); tick();

    jal(32'h3100); tick();
    jr31(32'h3200); #1 chk("misp_jr_flush", {31'b0, flush_if}, 32'd1);
    tick(); idle(); #1;
    chk("misp_pred_pc", pc, 32'h3100);
    chk("misp_flag", {31'b0, ras_mispredict}, 32'd1);
    chk("misp_flush", {31'b0, flush_if}, 32'd1);
    tick(); chk("misp_fix_pc", pc, 32'h3200);
    chk("misp_clear", {31'b0, ras_mispredict}, 32'd0);

    jal(32'h3300); tick();
    jr31(32'h3400); tick(); chk("rec_stall_pred", pc, 32'h3300);
    idle(); stall = 1; tick(); chk("rec_stall_fix", pc, 32'h3400);

    jal(32'h3600); tick(); chk("pre_stall_pc", pc, 32'h3100);
    idle(); stall = 1; #1 chk("stall_flush", {31'b0, flush_if}, 32'd0);
    tick(); chk("stall_hold", pc, 32'h3100);
    beq(32'h3008, 16'hFFFE, 1); stall = 1; exc_req = 1;
    #1 chk("exc_flush", {31'b0, flush_if}, 32'd1);
    tick(); chk("exc_pc", pc, 32'h4180);
    jal(32'h3700); stall = 1; tick(); chk("stall_jal_hold", pc, 32'h4180);
    jr31(32'h3600); tick(); chk("ras_kept", pc, 32'h3600);
    chk("ras_kept_misp", {31'b0, ras_mispredict}, 32'd0);

    idle(); eret_req = 1; epc = 32'h5000; tick(); chk("eret_pc", pc, 32'h5000);

    jal(32'h3800); tick();
    jr31(32'h3900); tick(); chk("rec_exc_pred", pc, 32'h3800);
    idle(); exc_req = 1; tick(); chk("rec_exc_pc", pc, 32'h4180);
    chk("rec_exc_misp", {31'b0, ras_mispredict}, 32'd0);

    jal(32'h3A00); tick();
    jr31(32'h3B00); tick(); chk("rec_rst_misp", {31'b0, ras_mispredict}, 32'd1);
    idle(); rst = 1; tick(); rst = 0;
    chk("rec_rst_pc", pc, 32'h3000);
    tick(); chk("rec_rst_seq", pc, 32'h3004);

    beq(32'hFFFF_FFF8, 16'h0004, 1); tick(); chk("beq_wrap", pc, 32'h0000_0008);
    idle(); id_valid = 1; pc_src = 2'd3; rs_val = 32'hFFFF_FFFC; tick();
    chk("jr_top_pc", pc, 32'hFFFF_FFFC);
    idle(); #1 chk("pc4_wrap", pc4, 32'h0);
    tick(); chk("seq_wrap", pc, 32'h0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
